// File: rtl/instruction_set.sv
// Shared ISA types for the ALU and its arbiter: op codes, flag word, arbiter states.
// Pure declarations; no timing or flow control lives here.
package instruction_set;

    localparam int ALU_W         = 16;
    localparam int ALU_REQ_PORTS = 2;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_CMP = 4'd2,
        ALU_INC = 4'd3,
        ALU_DEC = 4'd4,
        ALU_AND = 4'd5,
        ALU_OR  = 4'd6,
        ALU_XOR = 4'd7,
        ALU_NOP = 4'd8,
        ALU_ILL = 4'd9
    } ALU_OPS_T;

    // carry is a borrow for SUB/CMP/DEC
    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
    } FLAGS_T;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } ARB_STATE_T;

    function automatic logic op_sets_flags(input ALU_OPS_T op);
        return op inside {ALU_ADD, ALU_SUB, ALU_CMP, ALU_INC, ALU_DEC,
                          ALU_AND, ALU_OR, ALU_XOR};
    endfunction

endpackage

// File: rtl/arithmetic_logic_unit.sv
// 16-bit combinational ALU; zero latency, no flow control.
// Unknown op codes yield result 0 with all flags clear.
module arithmetic_logic_unit
    import instruction_set::*;
(
    input  logic [ALU_W-1:0] i_a,
    input  logic [ALU_W-1:0] i_b,
    input  ALU_OPS_T         i_op,
    output logic [ALU_W-1:0] o_result,
    output FLAGS_T           o_flags
);

    logic [ALU_W:0]   w_ext;
    logic [ALU_W-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_known;

    always_comb begin
        w_ext   = '0;
        w_res   = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        w_known = 1'b1;
        case (i_op)
            ALU_ADD: begin
                w_ext = {1'b0, i_a} + {1'b0, i_b};
                w_res = w_ext[ALU_W-1:0];
                w_c   = w_ext[ALU_W];
                w_v   = (i_a[ALU_W-1] == i_b[ALU_W-1]) && (w_res[ALU_W-1] != i_a[ALU_W-1]);
            end
            ALU_SUB, ALU_CMP: begin
                w_ext = {1'b0, i_a} - {1'b0, i_b};
                w_res = w_ext[ALU_W-1:0];
                w_c   = w_ext[ALU_W];
                w_v   = (i_a[ALU_W-1] != i_b[ALU_W-1]) && (w_res[ALU_W-1] != i_a[ALU_W-1]);
            end
            ALU_INC: begin
                w_ext = {1'b0, i_a} + {{ALU_W{1'b0}}, 1'b1};
                w_res = w_ext[ALU_W-1:0];
                w_c   = w_ext[ALU_W];
                w_v   = ~i_a[ALU_W-1] & w_res[ALU_W-1];
            end
            ALU_DEC: begin
                w_ext = {1'b0, i_a} - {{ALU_W{1'b0}}, 1'b1};
                w_res = w_ext[ALU_W-1:0];
                w_c   = w_ext[ALU_W];
                w_v   = i_a[ALU_W-1] & ~w_res[ALU_W-1];
            end
            ALU_AND: w_res = i_a & i_b;
            ALU_OR:  w_res = i_a | i_b;
            ALU_XOR: w_res = i_a ^ i_b;
            default: w_known = 1'b0;
        endcase
    end

    always_comb begin
        o_result = w_res;
        o_flags  = '0;
        if (w_known) begin
            o_flags.carry    = w_c;
            o_flags.zero     = (w_res == '0);
            o_flags.negative = w_res[ALU_W-1];
            o_flags.overflow = w_v;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two requesters; accept -> response is 2 cycles, 1 op per 3 cycles max.
// Response is held until rsp_ready of the owning port; no new request is accepted meanwhile.
module alu_arbiter
    import instruction_set::*;
#(
    parameter int FLAGS_OWNER = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ALU_REQ_PORTS-1:0] req_valid,
    output logic [ALU_REQ_PORTS-1:0] req_ready,
    input  logic [ALU_W-1:0]         req0_a,
    input  logic [ALU_W-1:0]         req0_b,
    input  ALU_OPS_T                 req0_op,
    input  logic [ALU_W-1:0]         req1_a,
    input  logic [ALU_W-1:0]         req1_b,
    input  ALU_OPS_T                 req1_op,
    output logic [ALU_REQ_PORTS-1:0] rsp_valid,
    input  logic [ALU_REQ_PORTS-1:0] rsp_ready,
    output logic [ALU_W-1:0]         rsp_result,
    output FLAGS_T                   rsp_flags,
    input  logic                     flags_we,
    input  FLAGS_T                   flags_wdata,
    output FLAGS_T                   flags_q
);

    localparam logic OWNER_IDX = 1'(FLAGS_OWNER);

    ARB_STATE_T       r_state;
    ARB_STATE_T       w_state_nxt;
    logic [ALU_W-1:0] r_a;
    logic [ALU_W-1:0] r_b;
    ALU_OPS_T         r_op;
    logic [ALU_W-1:0] r_res;
    FLAGS_T           r_fl;
    logic             r_owner;
    logic             r_last;

    logic             w_grant;
    logic             w_grant_vld;
    logic             w_accept;
    logic             w_flag_upd;
    logic [ALU_W-1:0] w_alu_res;
    FLAGS_T           w_alu_fl;

    // On a tie the port that did not win last time goes first
    always_comb begin
        w_grant_vld = |req_valid;
        case (req_valid)
            2'b01:   w_grant = 1'b0;
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = ~r_last;
            default: w_grant = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        rsp_valid   = '0;
        case (r_state)
            IDLE: begin
                if (w_grant_vld) begin
                    req_ready[w_grant] = ~rst;
                    w_state_nxt        = EXEC;
                end
            end
            EXEC: w_state_nxt = RESP;
            RESP: begin
                rsp_valid[r_owner] = ~rst;
                if (rsp_ready[r_owner]) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept   = (r_state == IDLE) && w_grant_vld;
    assign w_flag_upd = (r_state == EXEC) && (r_owner == OWNER_IDX) && op_sets_flags(r_op);

    arithmetic_logic_unit u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (r_op),
        .o_result (w_alu_res),
        .o_flags  (w_alu_fl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= ALU_ADD;
            r_res   <= '0;
            r_fl    <= '0;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            if (w_accept) begin
                r_a     <= w_grant ? req1_a  : req0_a;
                r_b     <= w_grant ? req1_b  : req0_b;
                r_op    <= w_grant ? req1_op : req0_op;
                r_owner <= w_grant;
                r_last  <= w_grant;
            end
            if (r_state == EXEC) begin
                r_res <= w_alu_res;
                r_fl  <= w_alu_fl;
            end
        end
    end

    // An external write beats a same-edge update from a completing op
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else if (flags_we) begin
            flags_q <= flags_wdata;
        end else if (w_flag_upd) begin
            flags_q <= w_alu_fl;
        end
    end

    assign rsp_result = r_res;
    assign rsp_flags  = r_fl;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a transaction-level model.
module tb_alu_arbiter;
    import instruction_set::*;

    localparam int OWNER = 0;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b, rsp_result;
    ALU_OPS_T    req0_op, req1_op;
    FLAGS_T      rsp_flags, flags_wdata, flags_q;
    logic        flags_we;

    alu_arbiter #(.FLAGS_OWNER(OWNER)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .flags_we   (flags_we),
        .flags_wdata(flags_wdata),
        .flags_q    (flags_q)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic done on signed/unsigned integers, flags as {carry,zero,negative,overflow}
    function automatic void golden(input ALU_OPS_T op, input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] r, output logic [3:0] f);
        int ua, ub, sa, sb, u, s;
        bit arith, lop, c, v;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        u = 0; s = 0; arith = 0; lop = 0; c = 0;
        case (op)
            ALU_ADD: begin u = ua + ub; s = sa + sb; arith = 1; c = (u > 65535); end
            ALU_SUB, ALU_CMP: begin u = ua - ub; s = sa - sb; arith = 1; c = (ua < ub); end
            ALU_INC: begin u = ua + 1; s = sa + 1; arith = 1; c = (u > 65535); end
            ALU_DEC: begin u = ua - 1; s = sa - 1; arith = 1; c = (ua < 1); end
            ALU_AND: begin u = ua & ub; lop = 1; end
            ALU_OR:  begin u = ua | ub; lop = 1; end
            ALU_XOR: begin u = ua ^ ub; lop = 1; end
            default: ;
        endcase
        r = u[15:0];
        v = arith && (s > 32767 || s < -32768);
        if (arith || lop) f = {c, (r == 16'd0), r[15], v};
        else              f = 4'd0;
    endfunction

    function automatic bit sets_flags(input ALU_OPS_T op);
        return op inside {ALU_ADD, ALU_SUB, ALU_CMP, ALU_INC, ALU_DEC, ALU_AND, ALU_OR, ALU_XOR};
    endfunction

    function automatic int pick(input logic [1:0] v, input int last);
        if (v == 2'b11) return (last == 0) ? 1 : 0;
        return v[0] ? 0 : 1;
    endfunction

    // Transaction model: one op in flight, age 1 = computing, age >= 2 = answer offered
    bit          m_busy  = 0;
    int          m_age   = 0;
    int          m_own   = 0;
    int          m_last  = 1;
    ALU_OPS_T    m_op    = ALU_ADD;
    logic [15:0] m_res   = '0;
    logic [3:0]  m_fl    = '0;
    logic [3:0]  m_flags = '0;
    logic [1:0]  m_acc   = '0;

    always @(posedge clk) begin : model
        logic [3:0] nf;
        int g;
        m_acc = 2'b00;
        if (rst) begin
            m_busy = 0; m_age = 0; m_last = 1; m_flags = '0;
        end else begin
            nf = m_flags;
            if (m_busy) begin
                if (m_age == 1) begin
                    if (m_own == OWNER && sets_flags(m_op)) nf = m_fl;
                    m_age = 2;
                end else if (rsp_ready[m_own]) begin
                    m_busy = 0;
                end
            end else if (req_valid != 2'b00) begin
                g = pick(req_valid, m_last);
                m_busy = 1; m_age = 1; m_own = g; m_last = g; m_acc[g] = 1'b1;
                if (g == 0) begin m_op = req0_op; golden(req0_op, req0_a, req0_b, m_res, m_fl); end
                else        begin m_op = req1_op; golden(req1_op, req1_a, req1_b, m_res, m_fl); end
            end
            if (flags_we) nf = flags_wdata;
            m_flags = nf;
        end
    end

    always @(negedge clk) begin : compare
        logic [1:0] er, ev;
        if (chk_en) begin
            er = 2'b00; ev = 2'b00;
            if (!rst && !m_busy && req_valid != 2'b00) er[pick(req_valid, m_last)] = 1'b1;
            if (!rst && m_busy && m_age >= 2) ev[m_own] = 1'b1;
            chk("req_ready", req_ready, er);
            chk("rsp_valid", rsp_valid, ev);
            if (ev != 2'b00) begin
                chk("rsp_result", rsp_result, m_res);
                chk("rsp_flags", rsp_flags, m_fl);
            end
            chk("flags_q", flags_q, m_flags);
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input ALU_OPS_T op, input logic [15:0] a, input logic [15:0] b);
        if (p == 0) begin req0_op = op; req0_a = a; req0_b = b; end
        else        begin req1_op = op; req1_a = a; req1_b = b; end
        req_valid[p] = 1'b1;
    endtask

    task automatic grant(input logic [1:0] exp, input bit keep, input string nm);
        bit seen;
        logic [1:0] got;
        seen = 0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) seen = 1;
        end
        got = req_ready;
        chk(nm, got, exp);
        sync();
        if (!keep) req_valid = req_valid & ~got;
    endtask

    function automatic logic [15:0] rand16();
        case ($urandom_range(0, 4))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = '0; rsp_ready = '0; flags_we = 1'b0; flags_wdata = '0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; req0_op = ALU_ADD; req1_op = ALU_ADD;
        repeat (2) @(posedge clk);
        #1 chk_en = 1;
        @(negedge clk);
        chk("reset_req_ready", req_ready, 2'b00);
        chk("reset_rsp_valid", rsp_valid, 2'b00);
        chk("reset_flags_q", flags_q, 4'h0);
        sync();
        rst = 1'b0;

        // single ADD from port 0
        rsp_ready = 2'b11;
        drive(0, ALU_ADD, 16'h7FFF, 16'h0001);
        grant(2'b01, 0, "single_grant");
        @(negedge clk); chk("single_exec_no_rsp", rsp_valid, 2'b00);
        @(negedge clk);
        chk("single_rsp_valid", rsp_valid, 2'b01);
        chk("single_result", rsp_result, 16'h8000);
        chk("single_flags", rsp_flags, 4'h3);
        sync();
        @(negedge clk); chk("single_flags_q", flags_q, 4'h3);
        sync();

        // tie from reset: 0,1,0,1
        rst = 1'b1;
        drive(0, ALU_ADD, 16'hFFFF, 16'h0001);
        drive(1, ALU_SUB, 16'h0003, 16'h0005);
        sync(); sync();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            grant((k % 2 == 1) ? 2'b10 : 2'b01, 1, "tie_grant");
            @(negedge clk);
            @(negedge clk);
            if (k % 2 == 1) begin
                chk("tie_p1_rsp_valid", rsp_valid, 2'b10);
                chk("tie_p1_result", rsp_result, 16'hFFFE);
                chk("tie_p1_flags", rsp_flags, 4'hA);
            end
            sync();
        end
        req_valid = 2'b00;
        @(negedge clk); chk("tie_flags_q", flags_q, 4'hC);
        sync();

        // response back-pressure; non-owner rsp_ready must be ignored
        rsp_ready = 2'b10;
        drive(0, ALU_ADD, 16'h0002, 16'h0003);
        drive(1, ALU_XOR, 16'hF0F0, 16'h0FF0);
        grant(2'b01, 0, "bp_grant_p0");
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 2'b01);
            chk("bp_result", rsp_result, 16'h0005);
            chk("bp_flags", rsp_flags, 4'h0);
            chk("bp_req_ready", req_ready, 2'b00);
        end
        sync();
        rsp_ready = 2'b01;
        grant(2'b10, 0, "bp_grant_p1");
        rsp_ready = 2'b11;
        repeat (3) sync();

        // external flags write collides with owner CMP completion
        drive(0, ALU_CMP, 16'h0004, 16'h0004);
        grant(2'b01, 0, "col_grant");
        flags_we = 1'b1; flags_wdata = FLAGS_T'(4'h0);
        sync();
        flags_we = 1'b0;
        @(negedge clk);
        chk("col_rsp_flags", rsp_flags, 4'h4);
        chk("col_result", rsp_result, 16'h0000);
        chk("col_flags_q", flags_q, 4'h0);
        sync();

        // reset during EXEC drops the op and clears flags
        flags_we = 1'b1; flags_wdata = FLAGS_T'(4'hF);
        sync();
        flags_we = 1'b0;
        drive(0, ALU_ADD, 16'h7FFF, 16'h0001);
        grant(2'b01, 0, "rexec_grant");
        rst = 1'b1;
        sync();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rexec_no_rsp", rsp_valid, 2'b00);
        end
        chk("rexec_flags_q", flags_q, 4'h0);
        sync();
        drive(0, ALU_INC, 16'h7FFF, 16'h0000);
        drive(1, ALU_DEC, 16'h0000, 16'h0000);
        grant(2'b01, 0, "rexec_tie_p0");
        grant(2'b10, 0, "rexec_then_p1");
        repeat (3) sync();

        // non-ALU op from the owner leaves flags alone
        flags_we = 1'b1; flags_wdata = FLAGS_T'(4'h8);
        sync();
        flags_we = 1'b0;
        drive(0, ALU_NOP, 16'h1234, 16'h5678);
        grant(2'b01, 0, "nop_grant");
        @(negedge clk);
        @(negedge clk);
        chk("nop_rsp_valid", rsp_valid, 2'b01);
        chk("nop_result", rsp_result, 16'h0000);
        sync();
        @(negedge clk); chk("nop_flags_q", flags_q, 4'h8);
        sync();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (req_valid[p] && m_acc[p]) req_valid[p] = 1'b0;
                if (!req_valid[p]) begin
                    if (p == 0) begin req0_a = rand16(); req0_b = rand16(); req0_op = ALU_OPS_T'(4'($urandom_range(0, 9))); end
                    else        begin req1_a = rand16(); req1_b = rand16(); req1_op = ALU_OPS_T'(4'($urandom_range(0, 9))); end
                    if ($urandom_range(0, 2) == 0) req_valid[p] = 1'b1;
                end
            end
            rsp_ready   = 2'($urandom_range(0, 3));
            flags_we    = ($urandom_range(0, 7) == 0);
            flags_wdata = FLAGS_T'(4'($urandom_range(0, 15)));
            rst         = ($urandom_range(0, 199) == 0);
            sync();
        end
        rst = 1'b0; req_valid = 2'b00; flags_we = 1'b0; rsp_ready = 2'b11;
        repeat (6) sync();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 16-bit `arithmetic_logic_unit` between two requesters: the execute stage (port 0) and the address/branch unit (port 1). Arbitration is round-robin, and the block runs a three-state accept/execute/respond sequence. It returns result and flags on a held response handshake, and it owns the architectural flags register updated by the designated owner port. It sits between the core's issue logic and the ALU, replacing direct ALU instantiation.

## Interface
Parameters:
- `FLAGS_OWNER`, default 0: requester index whose completed ops update `flags_q`.

Ports:
- `clk` in 1: clock. Reset is synchronous and active-high; all state updates on the rising edge of `clk`.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 2: per-port request valid. Must be held until accepted.
- `req_ready` out 2: per-port accept. At most one bit is high.
- `req0_a`, `req0_b` in 16 each: port 0 operands.
- `req0_op` in `ALU_OPS_T`: port 0 operation.
- `req1_a`, `req1_b` in 16 each: port 1 operands.
- `req1_op` in `ALU_OPS_T`: port 1 operation.
- `rsp_valid` out 2: per-port response valid. At most one bit is high.
- `rsp_ready` in 2: per-port response accept.
- `rsp_result` out 16: shared result bus.
- `rsp_flags` out `FLAGS_T`: flags produced by this op.
- `flags_we` in 1: external flags write (interrupt return, restore).
- `flags_wdata` in `FLAGS_T`: external flags value.
- `flags_q` out `FLAGS_T`: architectural flags register.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Compute grant from `req_valid` and the `last_q` pointer.
    - One requester valid: it wins.
    - Both valid: the port not equal to `last_q` wins.
  - Assert `req_ready[g]` for winner `g` only.
  - On `req_valid[g] & req_ready[g]`:
    - Latch operands/op into `a_q`, `b_q`, `op_q`.
    - Set `owner_q` = g and `last_q` = g.
    - Go to EXEC.
  - No valid requester: stay in IDLE, `req_ready` = 0.
- **EXEC**
  - The ALU is driven from `a_q`, `b_q`, `op_q`.
  - Capture the ALU output into `res_q` and `fl_q`, then go to RESP.
  - `req_ready` = 0.
- **RESP**
  - `rsp_valid[owner_q]` = 1; `rsp_result` = `res_q`; `rsp_flags` = `fl_q`.
  - On `rsp_ready[owner_q]`: go to IDLE.
  - `rsp_ready` of the non-owner port is ignored.
- **Flags register**
  - `flags_q` is written on the EXEC→RESP edge when `owner_q` == `FLAGS_OWNER` and `op_q` is one of ADD, SUB, CMP, INC, DEC, AND, OR, XOR.
  - Any other `ALU_OPS_T` value returns the ALU output (0) and leaves `flags_q` unchanged.
  - CMP returns its difference on `rsp_result`; the requester discards it.
- **Simultaneous `flags_we` and ALU flag update:** `flags_we` wins, and `flags_q` = `flags_wdata`.
- **`flags_we` in any other cycle:** `flags_q` = `flags_wdata` on the next edge, independent of FSM state.
- **Arithmetic:** fully delegated to the ALU. The block never modifies result or flag bits.

## Timing
- **Reset (synchronous, `rst` high at an edge):**
  - State returns to IDLE.
  - `last_q` = 1, so port 0 wins the first tie.
  - `flags_q` = 0, `res_q` = 0, `fl_q` = 0, `owner_q` = 0.
  - `req_ready` = 0 and `rsp_valid` = 0 during and after reset until the next IDLE evaluation.
- **Reset mid-operation (EXEC or RESP):**
  - The in-flight op is dropped without a response.
  - `flags_q` is cleared even if an update was due on that edge.
- **Latency:**
  - Accept edge N.
  - EXEC in cycle N+1.
  - `rsp_valid` high from cycle N+2, held until `rsp_ready`.
- **Throughput:** maximum one op per 3 cycles, achieved when `rsp_ready` is high on the first RESP cycle.
- **Holding rules:**
  - `rsp_result` and `rsp_flags` stay stable while `rsp_valid` is high.
  - Operand changes on the requester side after acceptance have no effect.
- `req_ready` depends combinationally on `req_valid`. No other combinational input→output paths exist.

## Structure
- Types come from `instruction_set`: `ALU_OPS_T` and `FLAGS_T`.
- Add to that package:
  - FSM state enum `ARB_STATE_T` (IDLE, EXEC, RESP).
  - Constant `ALU_REQ_PORTS` = 2.
- A single instance of `arithmetic_logic_unit` is the only sub-module. The arbitration, FSM and flags register are written inline.

## Test plan
- **Single request:** port 0 requests ADD 0x7FFF + 0x0001.
  - Accepted on edge 0.
  - `rsp_valid[0]` on cycle 2 with result 0x8000 and overflow=1, negative=1.
  - `flags_q` updated.
- **Tie, round-robin:** both ports valid from reset.
  - Grants come in order 0, 1, 0, 1.
  - Port 1 SUB 0x0003 − 0x0005 returns 0xFFFE with carry=1, negative=1.
  - `flags_q` is not changed by port 1 ops.
- **Response back-pressure:** `rsp_ready[0]` is held low for 5 cycles.
  - `rsp_valid[0]`, result and flags stay stable.
  - `req_ready` stays 0 throughout.
  - Port 1 is granted only after the handshake completes.
- **Flags write collision:** `flags_we` with wdata = 0 in the same cycle as an owner CMP 0x0004 vs 0x0004 completes.
  - `flags_q` = 0, and zero is not set.
  - `rsp_flags` still shows zero=1.
- **Reset during EXEC:**
  - No `rsp_valid` is seen and `flags_q` = 0.
  - After reset, simultaneous requests grant port 0 first.
- **Non-ALU op code from owner:**
  - Result 0 is returned.
  - `flags_q` is unchanged from its prior value of carry=1.
